bundle_slot_queue: RTL and testbench

- Sits between the instruction fetch/align stage and the per-slot instruction decoders.
- Buffers fetched 128-bit bundles and splits each into three 40-bit slots.
- Derives each slot's 3-bit execution unit code from the bundle template.
- Presents the two oldest undecoded slots on two decode lanes; the consumer takes 0, 1 or 2 per cycle.

---
 rtl/bundle_slot_queue.sv | 199 +++++++++++++++++++
 tb/tb_bundle_slot_queue.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bundle_slot_queue.sv
// bundle_slot_queue
// Buffers fetched 128-bit bundles and splits each one into three 40-bit slots.
// Each slot gets a 3-bit execution unit code taken from the bundle template.
// The two oldest undecoded slots are presented on two decode lanes.
// The consumer retires 0, 1 or 2 of them per cycle.
//
// Bundle layout: slot0 [39:0], slot1 [79:40], slot2 [119:80], template [127:120].
// Template bits [5:0] hold one 2-bit class per slot. Bit 6 is reserved.
// Bit 7 is the stop bit.
//
// Optional feature, macro BUNDLE_STOP_EN:
//   When defined, a head bundle with its stop bit set never pairs its last
//   slot with slot 0 of the following bundle. Lane 1 is held invalid, so
//   such a group cannot dual-issue across the bundle boundary.
//   When undefined, template[7] is ignored and the lanes span bundles freely.
module bundle_slot_queue #(
  parameter int DEPTH = 4,
  parameter int AMSB  = 31
) (
  input  logic                   rst,
  input  logic                   clk,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [127:0]           in_bundle,
  input  logic [AMSB:0]          in_pc,
  output logic                   out0_v,
  output logic [39:0]            out0_instr,
  output logic [2:0]             out0_unit,
  output logic [AMSB:0]          out0_pc,
  output logic                   out1_v,
  output logic [39:0]            out1_instr,
  output logic [2:0]             out1_unit,
  output logic [AMSB:0]          out1_pc,
  input  logic [1:0]             take,
  output logic [$clog2(DEPTH):0] bcount
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Extract slot n (0..2) from a bundle.
  function automatic logic [39:0] f_slot(input logic [127:0] b, input logic [1:0] n);
    logic [39:0] s;
    case (n)
      2'd0:    s = b[39:0];
      2'd1:    s = b[79:40];
      default: s = b[119:80];
    endcase
    return s;
  endfunction

  // Execution unit code for slot n: class from the template, and for memory
  // slots instr[34] separates a store from a load.
  function automatic logic [2:0] f_unit(input logic [127:0] b, input logic [1:0] n);
    logic [1:0]  cls;
    logic [39:0] ins;
    logic [2:0]  u;
    case (n)
      2'd0:    cls = b[121:120];
      2'd1:    cls = b[123:122];
      default: cls = b[125:124];
    endcase
    ins = f_slot(b, n);
    case (cls)
      2'd0:    u = 3'd1;
      2'd1:    u = 3'd2;
      2'd2:    u = 3'd3;
      default: u = ins[34] ? 3'd5 : 3'd4;
    endcase
    return u;
  endfunction

  // Slot address: bundle address with the slot index in the low bits.
  function automatic logic [AMSB:0] f_pc(input logic [AMSB-4:0] hi, input logic [1:0] n);
    return {hi, 2'b00, n};
  endfunction

  // Bundle storage. Only the upper address bits are kept, because a
  // bundle address always has its low 4 bits at zero.
  logic [127:0]    r_bundle [DEPTH];
  logic [AMSB-4:0] r_pc_hi  [DEPTH];

  // Control state
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [1:0]    r_sp;
  logic [CW-1:0] r_bcount;

  logic [PW-1:0]   w_rd_nx;
  logic [127:0]    w_head_b;
  logic [127:0]    w_next_b;
  logic [AMSB-4:0] w_head_pc;
  logic [AMSB-4:0] w_next_pc;
  logic            w_cross;
  logic            w_stop_block;
  logic            w_v0;
  logic            w_v1;
  logic [127:0]    w_l1_b;
  logic [AMSB-4:0] w_l1_pc;
  logic [1:0]      w_l1_n;
  logic [1:0]      w_nvalid;
  logic [1:0]      w_te;
  logic [2:0]      w_pos;
  logic [2:0]      w_pos_wrap;
  logic            w_pop;
  logic [1:0]      w_sp_nx;
  logic            w_push;
  logic [3:0]      w_unused_pc_lsb;

  assign w_unused_pc_lsb = in_pc[3:0];

  assign w_rd_nx   = r_rd + PW'(1);
  assign w_head_b  = r_bundle[r_rd];
  assign w_next_b  = r_bundle[w_rd_nx];
  assign w_head_pc = r_pc_hi[r_rd];
  assign w_next_pc = r_pc_hi[w_rd_nx];

  // Lane 1 comes from the next bundle once the head's last slot is on lane 0.
  assign w_cross = (r_sp == 2'd2);

`ifdef BUNDLE_STOP_EN
  assign w_stop_block = w_cross & w_head_b[127];
`else
  assign w_stop_block = 1'b0;
`endif

  assign w_v0    = (r_bcount != '0);
  assign w_v1    = w_cross ? ((r_bcount >= CW'(2)) & ~w_stop_block) : w_v0;
  assign w_l1_b  = w_cross ? w_next_b : w_head_b;
  assign w_l1_pc = w_cross ? w_next_pc : w_head_pc;
  assign w_l1_n  = w_cross ? 2'd0 : (r_sp + 2'd1);

  // Clamp the consumer's take to the number of valid lanes.
  // This keeps the slot pointer from ever walking into a bundle that is absent.
  assign w_nvalid   = {1'b0, w_v0} + {1'b0, w_v1};
  assign w_te       = (take > w_nvalid) ? w_nvalid : take;
  assign w_pos      = {1'b0, r_sp} + {1'b0, w_te};
  assign w_pos_wrap = w_pos - 3'd3;
  assign w_pop      = (w_pos >= 3'd3);
  assign w_sp_nx    = w_pop ? w_pos_wrap[1:0] : w_pos[1:0];

  // Readiness depends only on the registered count, so a pop in the same
  // cycle never opens room for a push while the queue is full.
  assign in_ready = (r_bcount < CW'(DEPTH));
  assign w_push   = in_valid & in_ready & ~flush;
  assign bcount   = r_bcount;

  // Pointer, slot position and occupancy update. Flush wins over push and take.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr     <= '0;
      r_rd     <= '0;
      r_sp     <= 2'd0;
      r_bcount <= '0;
    end else if (flush) begin
      r_rd     <= r_wr;
      r_sp     <= 2'd0;
      r_bcount <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= w_rd_nx;
      r_sp     <= w_sp_nx;
      r_bcount <= r_bcount + CW'(w_push) - CW'(w_pop);
    end
  end

  // Bundle payload write. Contents are qualified by the control state, so the
  // payload needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_bundle[r_wr] <= in_bundle;
      r_pc_hi[r_wr]  <= in_pc[AMSB:4];
    end
  end

  // Lane outputs decoded from the head (and next) bundle, zeroed when invalid.
  always_comb begin
    out0_v     = w_v0;
    out0_instr = '0;
    out0_unit  = '0;
    out0_pc    = '0;
    out1_v     = w_v1;
    out1_instr = '0;
    out1_unit  = '0;
    out1_pc    = '0;
    if (w_v0) begin
      out0_instr = f_slot(w_head_b, r_sp);
      out0_unit  = f_unit(w_head_b, r_sp);
      out0_pc    = f_pc(w_head_pc, r_sp);
    end
    if (w_v1) begin
      out1_instr = f_slot(w_l1_b, w_l1_n);
      out1_unit  = f_unit(w_l1_b, w_l1_n);
      out1_pc    = f_pc(w_l1_pc, w_l1_n);
    end
  end

endmodule

// File: tb/tb_bundle_slot_queue.sv
// Testbench for bundle_slot_queue (DEPTH=4, AMSB=31).
// The reference model keeps a flat queue of pending slots plus a bundle count.
// Optional BUNDLE_STOP_EN macro is honoured by the model.
module tb_bundle_slot_queue;

  localparam int DEPTH = 4;
  localparam int AMSB  = 31;

  logic         rst, clk, flush, in_valid, in_ready;
  logic [127:0] in_bundle;
  logic [31:0]  in_pc;
  logic         out0_v, out1_v;
  logic [39:0]  out0_instr, out1_instr;
  logic [2:0]   out0_unit, out1_unit;
  logic [31:0]  out0_pc, out1_pc;
  logic [1:0]   take;
  logic [2:0]   bcount;

  int checks = 0;
  int errors = 0;

  bundle_slot_queue #(.DEPTH(DEPTH), .AMSB(AMSB)) dut (
    .rst(rst), .clk(clk), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_bundle(in_bundle), .in_pc(in_pc),
    .out0_v(out0_v), .out0_instr(out0_instr), .out0_unit(out0_unit), .out0_pc(out0_pc),
    .out1_v(out1_v), .out1_instr(out1_instr), .out1_unit(out1_unit), .out1_pc(out1_pc),
    .take(take), .bcount(bcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rdy;
    logic [2:0]  bc;
    logic        v0;
    logic [39:0] i0;
    logic [2:0]  u0;
    logic [31:0] p0;
    logic        v1;
    logic [39:0] i1;
    logic [2:0]  u1;
    logic [31:0] p1;
  } obs_t;

  typedef struct {
    logic [39:0] instr;
    logic [2:0]  unit;
    logic [31:0] pc;
    int          idx;
    logic        stop;
  } slot_t;

  slot_t sq[$];
  int    bcnt;

  function automatic logic [2:0] ref_unit(input logic [1:0] cls, input logic [39:0] ins);
    if (cls == 2'd0) return 3'd1;
    if (cls == 2'd1) return 3'd2;
    if (cls == 2'd2) return 3'd3;
    return ins[34] ? 3'd5 : 3'd4;
  endfunction

  function automatic logic [127:0] mk_bundle(input logic [7:0] t, input logic [39:0] s0,
                                             input logic [39:0] s1, input logic [39:0] s2);
    return {t, s2, s1, s0};
  endfunction

  function automatic logic [127:0] rnd_bundle();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic obs_t exp_now();
    obs_t e;
    logic lane1_ok;
    e = '0;
    e.rdy = (bcnt < DEPTH);
    e.bc  = 3'(bcnt);
    if (sq.size() >= 1) begin
      e.v0 = 1'b1; e.i0 = sq[0].instr; e.u0 = sq[0].unit; e.p0 = sq[0].pc;
    end
    lane1_ok = (sq.size() >= 2);
`ifdef BUNDLE_STOP_EN
    if (lane1_ok && sq[0].idx == 2 && sq[0].stop) lane1_ok = 1'b0;
`endif
    if (lane1_ok) begin
      e.v1 = 1'b1; e.i1 = sq[1].instr; e.u1 = sq[1].unit; e.p1 = sq[1].pc;
    end
    return e;
  endfunction

  function automatic obs_t obs_now();
    obs_t o;
    o = {in_ready, bcount, out0_v, out0_instr, out0_unit, out0_pc,
         out1_v, out1_instr, out1_unit, out1_pc};
    return o;
  endfunction

  task automatic model_reset();
    sq.delete();
    bcnt = 0;
  endtask

  task automatic model_step(input logic iv, input logic [127:0] b, input logic [31:0] p,
                            input logic [1:0] tk, input logic fl);
    obs_t  e;
    int    nv, te;
    bit    ready;
    slot_t s;
    ready = (bcnt < DEPTH);
    if (fl) begin
      model_reset();
    end else begin
      e  = exp_now();
      nv = int'(e.v0) + int'(e.v1);
      te = (int'(tk) < nv) ? int'(tk) : nv;
      for (int k = 0; k < te; k++) begin
        s = sq.pop_front();
        if (s.idx == 2) bcnt--;
      end
      if (iv && ready) begin
        for (int n = 0; n < 3; n++) begin
          s.instr = b[40*n +: 40];
          s.unit  = ref_unit(b[120 + 2*n +: 2], s.instr);
          s.pc    = {p[31:4], 2'b00, 2'(n)};
          s.idx   = n;
          s.stop  = b[127];
          sq.push_back(s);
        end
        bcnt++;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, and land #1 after the edge.
  task automatic cycle(input logic iv, input logic [127:0] b, input logic [31:0] p,
                       input logic [1:0] tk, input logic fl);
    in_valid = iv; in_bundle = b; in_pc = p; take = tk; flush = fl;
    model_step(iv, b, p, tk, fl);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    obs_t o, e;
    rst = 1'b0; flush = 0; in_valid = 0; in_bundle = '0; in_pc = '0; take = 0;
    #1 rst = 1'b1;
    model_reset();
    #1;
    o = obs_now(); e = exp_now();
    checks++;
    if (o !== e || in_ready !== 1'b1 || bcount !== 3'd0) begin
      errors++; $display("FAIL reset_state got %h want %h", o, e);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    o = obs_now();
    checks++;
    if (o !== e) begin errors++; $display("FAIL reset_release got %h want %h", o, e); end
  endtask

  task automatic test_basic();
    logic [39:0] s0, s1, s2;
    obs_t o, e;
    s0 = {$urandom(), $urandom()}; s1 = {$urandom(), $urandom()}; s2 = {$urandom(), $urandom()};
    s1[34] = 1'b0;
    cycle(1, mk_bundle(8'b00_10_01_00, s0, s1, s2), 32'h100, 0, 0);
    checks++;
    if (out0_v !== 1 || out0_unit !== 3'd1 || out0_pc !== 32'h100 || out0_instr !== s0) begin
      errors++; $display("FAIL basic_lane0 got v=%b u=%0d pc=%h i=%h want v=1 u=1 pc=100 i=%h",
                         out0_v, out0_unit, out0_pc, out0_instr, s0);
    end
    checks++;
    if (out1_v !== 1 || out1_unit !== 3'd2 || out1_pc !== 32'h101 || out1_instr !== s1) begin
      errors++; $display("FAIL basic_lane1 got v=%b u=%0d pc=%h i=%h want v=1 u=2 pc=101 i=%h",
                         out1_v, out1_unit, out1_pc, out1_instr, s1);
    end
    checks++;
    if (bcount !== 3'd1) begin errors++; $display("FAIL basic_bcount got %0d want 1", bcount); end
    o = obs_now(); e = exp_now();
    checks++;
    if (o !== e) begin errors++; $display("FAIL basic_model got %h want %h", o, e); end
  endtask

  task automatic test_take2();
    logic [31:0] e0 [3];
    logic [31:0] e1 [3];
    e0[0] = 32'h100; e0[1] = 32'h102; e0[2] = 32'h111;
    e1[0] = 32'h101; e1[1] = 32'h110; e1[2] = 32'h112;
    cycle(0, '0, '0, 0, 1);
    cycle(1, mk_bundle(8'h24, 40'h1, 40'h2, 40'h3), 32'h100, 0, 0);
    cycle(1, mk_bundle(8'h06, 40'h4, 40'h5, 40'h6), 32'h110, 0, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out0_v !== 1 || out1_v !== 1 || out0_pc !== e0[k] || out1_pc !== e1[k]) begin
        errors++; $display("FAIL take2_step%0d got %h/%h want %h/%h", k, out0_pc, out1_pc, e0[k], e1[k]);
      end
      cycle(0, '0, '0, 2, 0);
    end
    checks++;
    if (out0_v !== 0 || out1_v !== 0 || bcount !== 3'd0) begin
      errors++; $display("FAIL take2_drain got v0=%b v1=%b bc=%0d want 0 0 0", out0_v, out1_v, bcount);
    end
  endtask

  task automatic test_mem_unit();
    logic [39:0] s0, s1, s2;
    s0 = 40'h04_0000_0000; s1 = 40'hFB_FFFF_FFFF; s2 = 40'h04_1234_5678;
    cycle(0, '0, '0, 0, 1);
    cycle(1, mk_bundle(8'h3F, s0, s1, s2), 32'h3000, 0, 0);
    checks++;
    if (out0_unit !== 3'd5 || out1_unit !== 3'd4) begin
      errors++; $display("FAIL mem_unit_a got %0d/%0d want 5/4", out0_unit, out1_unit);
    end
    cycle(0, '0, '0, 2, 0);
    checks++;
    if (out0_unit !== 3'd5 || out0_pc !== 32'h3002 || out1_v !== 0) begin
      errors++; $display("FAIL mem_unit_b got u=%0d pc=%h v1=%b want 5 3002 0", out0_unit, out0_pc, out1_v);
    end
  endtask

  task automatic test_full();
    obs_t o, e;
    cycle(0, '0, '0, 0, 1);
    for (int k = 0; k < DEPTH; k++) cycle(1, rnd_bundle(), 32'h400 + 32'(k) * 32'h10, 0, 0);
    checks++;
    if (in_ready !== 0 || bcount !== 3'd4) begin
      errors++; $display("FAIL full_state got rdy=%b bc=%0d want 0 4", in_ready, bcount);
    end
    cycle(1, rnd_bundle(), 32'h500, 0, 0);
    o = obs_now(); e = exp_now();
    checks++;
    if (o !== e || bcount !== 3'd4) begin errors++; $display("FAIL full_ignore got %h want %h", o, e); end
    for (int k = 0; k < 3; k++) begin
      cycle(1, rnd_bundle(), 32'h600, 1, 0);
      checks++;
      if (bcount !== ((k == 2) ? 3'd3 : 3'd4) || in_ready !== (k == 2)) begin
        errors++; $display("FAIL full_take1_%0d got bc=%0d rdy=%b", k, bcount, in_ready);
      end
    end
    o = obs_now(); e = exp_now();
    checks++;
    if (o !== e) begin errors++; $display("FAIL full_after got %h want %h", o, e); end
  endtask

  task automatic test_flush();
    cycle(0, '0, '0, 0, 1);
    for (int k = 0; k < 3; k++) cycle(1, rnd_bundle(), 32'h700 + 32'(k) * 32'h10, 0, 0);
    checks++;
    if (bcount !== 3'd3) begin errors++; $display("FAIL flush_pre got bc=%0d want 3", bcount); end
    cycle(1, rnd_bundle(), 32'h800, 2, 1);
    checks++;
    if (bcount !== 0 || out0_v !== 0 || out1_v !== 0 || in_ready !== 1) begin
      errors++; $display("FAIL flush_state got bc=%0d v0=%b v1=%b want 0 0 0", bcount, out0_v, out1_v);
    end
    cycle(0, '0, '0, 0, 0);
    checks++;
    if (bcount !== 0 || out0_v !== 0) begin
      errors++; $display("FAIL flush_drop got bc=%0d v0=%b want 0 0", bcount, out0_v);
    end
  endtask

  task automatic test_stop();
    logic exp_v1;
    logic [31:0] exp_pc0;
    cycle(0, '0, '0, 0, 1);
    cycle(1, mk_bundle(8'h80, 40'hA0, 40'hA1, 40'hA2), 32'h200, 0, 0);
    cycle(1, mk_bundle(8'h00, 40'hB0, 40'hB1, 40'hB2), 32'h210, 0, 0);
    cycle(0, '0, '0, 2, 0);
`ifdef BUNDLE_STOP_EN
    exp_v1 = 1'b0; exp_pc0 = 32'h210;
`else
    exp_v1 = 1'b1; exp_pc0 = 32'h211;
`endif
    checks++;
    if (out0_pc !== 32'h202 || bcount !== 3'd2 || out1_v !== exp_v1 ||
        (exp_v1 && (out1_pc !== 32'h210 || out1_instr !== 40'hB0))) begin
      errors++; $display("FAIL stop_lane1 got v1=%b pc=%h want v1=%b", out1_v, out1_pc, exp_v1);
    end
    cycle(0, '0, '0, 2, 0);
    checks++;
    if (bcount !== 3'd1 || out0_pc !== exp_pc0) begin
      errors++; $display("FAIL stop_take got bc=%0d pc0=%h want 1 %h", bcount, out0_pc, exp_pc0);
    end
  endtask

  task automatic test_random();
    obs_t o, e;
    int bad = 0;
    cycle(0, '0, '0, 0, 1);
    for (int k = 0; k < 800; k++) begin
      cycle(($urandom_range(0, 3) != 0), rnd_bundle(), $urandom() & 32'hFFFF_FFF0,
            2'($urandom_range(0, 2)), ($urandom_range(0, 59) == 0));
      o = obs_now(); e = exp_now();
      checks++;
      if (o !== e) begin
        errors++;
        if (bad < 8) $display("FAIL random_cyc%0d got %h want %h", k, o, e);
        bad++;
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o, e;
    cycle(0, '0, '0, 0, 1);
    for (int k = 0; k < 3; k++) cycle(1, rnd_bundle(), 32'h900 + 32'(k) * 32'h10, 0, 0);
    cycle(0, '0, '0, 1, 0);
    in_valid = 0; take = 0; flush = 0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    o = obs_now(); e = exp_now();
    checks++;
    if (o !== e) begin errors++; $display("FAIL reset_mid got %h want %h", o, e); end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    cycle(1, mk_bundle(8'h00, 40'h11, 40'h22, 40'h33), 32'hA00, 0, 0);
    o = obs_now(); e = exp_now();
    checks++;
    if (o !== e || out0_pc !== 32'hA00 || bcount !== 3'd1) begin
      errors++; $display("FAIL reset_mid_push got %h want %h", o, e);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_take2();
    test_mem_unit();
    test_full();
    test_flush();
    test_stop();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
